mandel_frame_sched: RTL and testbench

Frame scheduler for the Mandelbrot renderer. Latches a viewport (top-left corner plus pixel step) and walks an H_RES×V_RES raster in row-major order. Computes each pixel's complex coordinate c and dispatches it to a pool of NUM_CORES iteration cores. Collects the cores' out-of-order results and emits them as a tagged pixel stream to the colour/framebuffer stage.

---
 rtl/mandel_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/mandel_frame_sched.sv | 133 +++++++++++++
 tb/tb_mandel_frame_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// mandel_pkg: shared widths, scheduler state and pixel tag types for the Mandelbrot renderer
package mandel_pkg;
  localparam int COORD_W = 32;
  localparam int ITER_W = 8;
  localparam logic [ITER_W-1:0] MAX_ITER = '1;
  localparam int TAG_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} sched_state_t;
  typedef struct packed {
    logic [TAG_W-1:0] x;
    logic [TAG_W-1:0] y;
  } pix_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; priority restarts just after the last advanced grant
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] r_ptr, w_lo, w_hi;
  logic w_hit;
  // w_hi: first request at or above the pointer; w_lo: wrap-around fallback
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    w_hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) w_lo = IW'(i);
      if (i_req[i] && i >= int'(r_ptr)) begin
        w_hi = IW'(i);
        w_hit = 1'b1;
      end
    end
  end
  assign o_idx = w_hit ? w_hi : w_lo;
  assign o_grant = |i_req ? N'(1) << o_idx : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= '0;
    else if (i_advance && |i_req) r_ptr <= o_idx == IW'(N - 1) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/mandel_frame_sched.sv
// mandel_frame_sched: walks the raster, dispatches c to a core pool and
// collects out-of-order iteration results into a tagged pixel stream
module mandel_frame_sched #(
  parameter int H_RES = 256,
  parameter int V_RES = 256,
  parameter int NUM_CORES = 4,
  parameter int COORD_W = mandel_pkg::COORD_W,
  parameter int ITER_W = mandel_pkg::ITER_W,
  localparam int XW = H_RES > 1 ? $clog2(H_RES) : 1,
  localparam int YW = V_RES > 1 ? $clog2(V_RES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [COORD_W-1:0]          cfg_re0,
  input  logic [COORD_W-1:0]          cfg_im0,
  input  logic [COORD_W-1:0]          cfg_step,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_CORES-1:0]        core_req_valid,
  input  logic [NUM_CORES-1:0]        core_req_ready,
  output logic [COORD_W-1:0]          core_c_re,
  output logic [COORD_W-1:0]          core_c_im,
  input  logic [NUM_CORES-1:0]        core_res_valid,
  output logic [NUM_CORES-1:0]        core_res_ready,
  input  logic [NUM_CORES*ITER_W-1:0] core_res_iter,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [XW-1:0]               pix_x,
  output logic [YW-1:0]               pix_y,
  output logic [ITER_W-1:0]           pix_iter,
  output logic                        pix_in_set
);
  import mandel_pkg::*;
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  sched_state_t r_state, w_next;
  logic [COORD_W-1:0] r_re0, r_im0, r_step, r_re, r_im;
  logic [XW-1:0] r_x, r_px;
  logic [YW-1:0] r_y, r_py;
  logic [ITER_W-1:0] r_pit;
  logic [NUM_CORES-1:0] r_core_busy, w_dgnt, w_cgnt;
  logic [CW-1:0] w_didx, w_cidx;
  pix_tag_t r_tag [NUM_CORES];
  logic r_pv, w_run, w_coll, w_disp, w_acc, w_row_end, w_last, w_drained;
  assign w_run = r_state == RUN;
  assign w_coll = (r_state == RUN || r_state == DRAIN) && (!r_pv || pix_ready);
  assign w_disp = |w_dgnt;
  assign w_acc = |w_cgnt;
  assign w_row_end = r_x == XW'(H_RES - 1);
  assign w_last = w_row_end && r_y == YW'(V_RES - 1);
  assign w_drained = ~|r_core_busy && (!r_pv || pix_ready);
  rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
    .clk,
    .rst,
    .i_req(~r_core_busy & core_req_ready & {NUM_CORES{w_run}}),
    .i_advance(w_disp),
    .o_grant(w_dgnt),
    .o_idx(w_didx)
  );
  // only cores holding an outstanding pixel may hand back a result
  rr_arbiter #(.N(NUM_CORES)) u_coll_arb (
    .clk,
    .rst,
    .i_req(core_res_valid & r_core_busy & {NUM_CORES{w_coll}}),
    .i_advance(w_acc),
    .o_grant(w_cgnt),
    .o_idx(w_cidx)
  );
  always_comb begin
    w_next = r_state;
    busy = r_state != IDLE;
    done = r_state == FIN;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_disp && w_last ? DRAIN : RUN;
      DRAIN:   w_next = w_drained ? FIN : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_re0 <= '0;
      r_im0 <= '0;
      r_step <= '0;
      r_re <= '0;
      r_im <= '0;
      r_x <= '0;
      r_y <= '0;
      r_core_busy <= '0;
      for (int i = 0; i < NUM_CORES; i++) r_tag[i] <= '0;
      r_pv <= 1'b0;
      r_px <= '0;
      r_py <= '0;
      r_pit <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_re0 <= cfg_re0;
        r_im0 <= cfg_im0;
        r_step <= cfg_step;
        r_re <= cfg_re0;
        r_im <= cfg_im0;
        r_x <= '0;
        r_y <= '0;
      end else if (w_disp) begin
        r_tag[w_didx] <= '{x: TAG_W'(r_x), y: TAG_W'(r_y)};
        r_x <= w_row_end ? '0 : r_x + 1'b1;
        r_y <= w_row_end ? (w_last ? '0 : r_y + 1'b1) : r_y;
        r_re <= w_row_end ? r_re0 : r_re + r_step;
        r_im <= w_row_end ? r_im - r_step : r_im;
      end
      r_core_busy <= (r_core_busy | w_dgnt) & ~w_cgnt;
      if (w_acc) begin
        r_pv <= 1'b1;
        r_px <= r_tag[w_cidx].x[XW-1:0];
        r_py <= r_tag[w_cidx].y[YW-1:0];
        r_pit <= core_res_iter[w_cidx*ITER_W +: ITER_W];
      end else if (pix_ready) begin
        r_pv <= 1'b0;
      end
    end
  end
  assign core_req_valid = w_dgnt;
  assign core_res_ready = w_cgnt;
  assign core_c_re = r_re;
  assign core_c_im = r_im;
  assign pix_valid = r_pv;
  assign pix_x = r_px;
  assign pix_y = r_py;
  assign pix_iter = r_pit;
  assign pix_in_set = &r_pit;
endmodule

// File: tb/tb_mandel_frame_sched.sv
// tb_mandel_frame_sched: random-latency core models and a raster/scoreboard reference
module tb_mandel_frame_sched;
  localparam int H = 5, V = 3, N = 4, CW = 32, IW = 8;
  localparam int XW = $clog2(H), YW = $clog2(V);
  logic clk = 0, rst = 0, start = 0, pix_ready = 0;
  logic [CW-1:0] cfg_re0 = 0, cfg_im0 = 0, cfg_step = 0;
  logic busy, done, pix_valid, pix_in_set;
  logic [N-1:0] core_req_valid, core_res_ready;
  logic [N-1:0] core_req_ready = 0, core_res_valid = 0;
  logic [CW-1:0] core_c_re, core_c_im;
  logic [N*IW-1:0] core_res_iter = 0;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [IW-1:0] pix_iter;
  mandel_frame_sched #(.H_RES(H), .V_RES(V), .NUM_CORES(N), .COORD_W(CW), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_re0(cfg_re0), .cfg_im0(cfg_im0), .cfg_step(cfg_step),
    .busy(busy), .done(done), .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_c_re(core_c_re), .core_c_im(core_c_im), .core_res_valid(core_res_valid),
    .core_res_ready(core_res_ready), .core_res_iter(core_res_iter), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter), .pix_in_set(pix_in_set)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // stand-in for an iteration core: any deterministic function of c exposes mis-tagging
  function automatic logic [IW-1:0] iter_of(input logic [CW-1:0] re, input logic [CW-1:0] im);
    return re[28:21] ^ im[28:21];
  endfunction
  int c_st [N];
  int c_cnt [N];
  logic [IW-1:0] c_it [N];
  logic [CW-1:0] f_re0, f_im0, f_step, nxt_re0, nxt_im0, nxt_step;
  bit seen [H][V];
  int bx, by, n_disp, n_emit, n_done, n255, n254, cyc, t_start, grant_seq, stall_left, lat_max;
  bit nxt_start, rdy_rand, pix_rand, stall_req, stalled, prev_hold, hs_prev, after_reset;
  logic [XW+YW+IW:0] prev_pix;
  task automatic cycle();
    logic [N-1:0] dh;
    logic [CW-1:0] e_re, e_im;
    logic [IW-1:0] e_it;
    int x, y;
    @(negedge clk);
    start = nxt_start;
    cfg_re0 = nxt_re0;
    cfg_im0 = nxt_im0;
    cfg_step = nxt_step;
    for (int i = 0; i < N; i++) begin
      core_req_ready[i] = c_st[i] == 0 && (!rdy_rand || $urandom_range(3) != 0);
      core_res_valid[i] = c_st[i] == 2;
      core_res_iter[i*IW +: IW] = c_it[i];
    end
    pix_ready = stall_left > 0 ? 1'b0 : (!pix_rand || $urandom_range(3) != 0);
    if (stall_left > 0) stall_left--;
    #1;
    cyc++;
    dh = core_req_valid & core_req_ready;
    check("req_onehot", 64'($onehot0(core_req_valid)), 1);
    check("req_to_unready", core_req_valid & ~core_req_ready, 0);
    check("res_ready_invalid", core_res_ready & ~core_res_valid, 0);
    if (!busy) check("idle_no_req", core_req_valid, 0);
    if (prev_hold) check("pix_hold", {pix_valid, pix_x, pix_y, pix_iter}, prev_pix);
    if (pix_valid && !pix_ready) check("stall_no_res_ready", core_res_ready, 0);
    prev_hold = pix_valid && !pix_ready;
    prev_pix = {pix_valid, pix_x, pix_y, pix_iter};
    if (done) begin
      check("done_emitted", n_emit, H * V);
      check("done_after_last_hs", 64'(hs_prev), 1);
      n_done++;
    end
    hs_prev = pix_valid && pix_ready;
    if (pix_valid && pix_ready) begin
      x = int'(pix_x);
      y = int'(pix_y);
      check("pix_in_range", 64'(x < H && y < V), 1);
      if (x < H && y < V) begin
        e_re = f_re0 + f_step * x;
        e_im = f_im0 - f_step * y;
        e_it = iter_of(e_re, e_im);
        check("pix_dup", 64'(seen[x][y]), 0);
        seen[x][y] = 1;
        check("pix_iter", pix_iter, e_it);
        check("pix_in_set", pix_in_set, 64'(e_it == 8'hFF));
        if (e_it == 8'hFF) n255++;
        if (e_it == 8'hFE) n254++;
      end
      n_emit++;
    end
    for (int i = 0; i < N; i++) begin
      if (c_st[i] == 1) begin
        c_cnt[i]--;
        if (c_cnt[i] == 0) c_st[i] = 2;
      end
      if (core_res_valid[i] && core_res_ready[i]) c_st[i] = 0;
      if (dh[i]) begin
        e_re = f_re0 + f_step * bx;
        e_im = f_im0 - f_step * by;
        check("disp_count", 64'(n_disp < H * V), 1);
        check("disp_re", core_c_re, e_re);
        check("disp_im", core_c_im, e_im);
        if (after_reset && grant_seq < N) begin
          check("rr_first_core", i, grant_seq);
          check("rr_first_cycle", cyc, t_start + grant_seq);
          grant_seq++;
          if (grant_seq == N) after_reset = 0;
        end
        c_st[i] = 1;
        c_cnt[i] = $urandom_range(lat_max, 1);
        c_it[i] = iter_of(core_c_re, core_c_im);
        n_disp++;
        bx++;
        if (bx == H) begin
          bx = 0;
          by++;
        end
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req_valid", core_req_valid, 0);
    check("rst_res_ready", core_res_ready, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", {pix_x, pix_y, pix_iter, pix_in_set}, 0);
    check("rst_c_bus", {core_c_re, core_c_im}, 0);
    for (int i = 0; i < N; i++) c_st[i] = 0;
    core_req_ready = 0;
    core_res_valid = 0;
    core_res_iter = 0;
    start = 0;
    nxt_start = 0;
    prev_hold = 0;
    hs_prev = 0;
    stall_left = 0;
    after_reset = 1;
    grant_seq = 0;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic run_frame(input logic [CW-1:0] re0, input logic [CW-1:0] im0, input logic [CW-1:0] step,
                           input int abort_after);
    nxt_re0 = re0;
    nxt_im0 = im0;
    nxt_step = step;
    nxt_start = 1;
    cycle();
    check("idle_before_start", busy, 0);
    f_re0 = re0;
    f_im0 = im0;
    f_step = step;
    nxt_start = 0;
    {bx, by, n_disp, n_emit, n_done, n255, n254} = '0;
    stalled = 0;
    for (int x = 0; x < H; x++) for (int y = 0; y < V; y++) seen[x][y] = 0;
    t_start = cyc + 1;
    for (int k = 0; k < 4000 && n_done == 0; k++) begin
      if (abort_after > 0 && k == abort_after) begin
        do_reset();
        return;
      end
      if ($urandom_range(7) == 0) begin
        nxt_re0 = $urandom;
        nxt_im0 = $urandom;
        nxt_step = $urandom;
        nxt_start = 1'($urandom_range(1));
      end else begin
        nxt_start = 0;
      end
      if (stall_req && !stalled && pix_valid) begin
        stall_left = 50;
        stalled = 1;
      end
      cycle();
      if (k == 0) check("busy_after_start", busy, 1);
    end
    if (n_done == 0) begin
      check("frame_timeout", 0, 1);
      do_reset();
      return;
    end
    nxt_start = 0;
    cycle();
    check("busy_after_done", busy, 0);
    check("done_once", n_done, 1);
    check("frame_emitted", n_emit, H * V);
    check("frame_dispatched", n_disp, H * V);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      c_st[i] = 0;
      c_it[i] = 0;
    end
    {nxt_re0, nxt_im0, nxt_step} = '0;
    {rdy_rand, pix_rand, stall_req} = '0;
    lat_max = 20;
    cyc = 0;
    do_reset();
    run_frame(32'hC000_0000, 32'h2000_0000, 32'h2000_0000, 0);
    run_frame(32'h0000_0000, 32'h0000_0000, 32'h0020_0000, 0);
    check("saw_iter_255", 64'(n255 > 0), 1);
    check("saw_iter_254", 64'(n254 > 0), 1);
    rdy_rand = 1;
    pix_rand = 1;
    lat_max = 40;
    run_frame(32'h7FFF_FFF0, 32'h8000_0010, 32'h1000_0000, 0);
    for (int f = 0; f < 6; f++) begin
      stall_req = f[0];
      run_frame($urandom, $urandom, $urandom, 0);
    end
    stall_req = 0;
    run_frame($urandom, $urandom, $urandom, 10);
    rdy_rand = 0;
    run_frame(32'hC000_0000, 32'h2000_0000, 32'h0800_0000, 0);
    rdy_rand = 1;
    stall_req = 1;
    run_frame($urandom, $urandom, $urandom, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
